// File: rtl/uart_rx.sv
// UART 8N1 receiver driven by an 8x oversampling tick, with majority filter.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int DATA_BITS    = 8,
    parameter int SAMPLE_PHASE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Baud8Tick,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_frame_err,
    output logic       RxD_idle
`ifdef UART_RX_PARITY_EN
    ,
    output logic       RxD_parity_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t               r_state;
    state_t               w_state_n;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [2:0]           r_win;
    logic [2:0]           r_phase;
    logic [2:0]           w_phase_n;
    logic [2:0]           r_cnt;
    logic [2:0]           w_cnt_n;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_n;
    logic [7:0]           r_data;
    logic [7:0]           w_data_n;
    logic [7:0]           w_ext;
    logic                 r_ready;
    logic                 w_ready_n;
    logic                 r_ferr;
    logic                 w_ferr_n;
    logic                 r_perr;
    logic                 w_perr_n;
    logic                 r_par;
    logic                 w_par_n;
    logic                 w_filt;
    logic                 w_samp;

    assign w_filt = (r_win[0] & r_win[1]) | (r_win[0] & r_win[2]) |
                    (r_win[1] & r_win[2]);
    assign w_samp = Baud8Tick && (r_phase == 3'(SAMPLE_PHASE));

    always_comb begin
        w_ext                 = '0;
        w_ext[DATA_BITS-1:0]  = r_shift;
    end

    always_comb begin
        w_state_n = r_state;
        w_phase_n = Baud8Tick ? r_phase + 3'd1 : r_phase;
        w_cnt_n   = r_cnt;
        w_shift_n = r_shift;
        w_data_n  = r_data;
        w_ready_n = 1'b0;
        w_ferr_n  = 1'b0;
        w_perr_n  = 1'b0;
        w_par_n   = r_par;
        unique case (r_state)
            S_IDLE: begin
                w_par_n = 1'b0;
                if (Baud8Tick && !w_filt) begin
                    w_state_n = S_START;
                    w_phase_n = 3'd0;
                end
            end
            S_START: begin
                if (w_samp) begin
                    w_state_n = w_filt ? S_IDLE : S_DATA;
                    w_cnt_n   = 3'd0;
                end
            end
            S_DATA: begin
                if (w_samp) begin
                    w_shift_n = {w_filt, r_shift[DATA_BITS-1:1]};
                    w_cnt_n   = r_cnt + 3'd1;
                    if (r_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        w_state_n = S_PARITY;
`else
                        w_state_n = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_samp) begin
                    w_par_n   = w_filt ^ (^r_shift);
                    w_state_n = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_samp) begin
                    if (w_filt) begin
                        // parity mismatch swaps the ready strobe for perr
                        w_ready_n = !r_par;
                        w_perr_n  = r_par;
                        if (!r_par) w_data_n = w_ext;
                        w_state_n = S_IDLE;
                    end else begin
                        w_ferr_n  = 1'b1;
                        w_state_n = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (Baud8Tick && w_filt) w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_win   <= 3'b111;
            r_state <= S_IDLE;
            r_phase <= 3'd0;
            r_cnt   <= 3'd0;
            r_shift <= '0;
            r_data  <= 8'd0;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
            r_par   <= 1'b0;
        end else begin
            r_sync1 <= RxD;
            r_sync2 <= r_sync1;
            if (Baud8Tick) r_win <= {r_win[1:0], r_sync2};
            r_state <= w_state_n;
            r_phase <= w_phase_n;
            r_cnt   <= w_cnt_n;
            r_shift <= w_shift_n;
            r_data  <= w_data_n;
            r_ready <= w_ready_n;
            r_ferr  <= w_ferr_n;
            r_perr  <= w_perr_n;
            r_par   <= w_par_n;
        end
    end

    assign RxD_data       = r_data;
    assign RxD_data_ready = r_ready;
    assign RxD_frame_err  = r_ferr;
    assign RxD_idle       = (r_state == S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign RxD_parity_err = r_perr;
`else
    logic w_unused;
    assign w_unused = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frame table plus glitch/break/reset/parity cases.
module tb_uart_rx;

    localparam int BIT_CLK = 128;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CLK = FRAME_BITS * BIT_CLK;

    logic       clk;
    logic       rst;
    logic       Baud8Tick;
    logic       RxD;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_frame_err;
    logic       RxD_idle;
    logic       perr;

    uart_rx dut (
        .clk            (clk),
        .rst            (rst),
        .Baud8Tick      (Baud8Tick),
        .RxD            (RxD),
        .RxD_data       (RxD_data),
        .RxD_data_ready (RxD_data_ready),
        .RxD_frame_err  (RxD_frame_err),
        .RxD_idle       (RxD_idle)
`ifdef UART_RX_PARITY_EN
        ,
        .RxD_parity_err (perr)
`endif
    );

`ifndef UART_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         gap;
        int         exp_kind;
        logic [7:0] exp_data;
    } vec_t;

    exp_t exp_q[$];
    int   rdy_t[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_ready = 0;
    int   n_ferr = 0;
    int   n_perr = 0;
    int   want_ready = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        int t;
        t = 0;
        Baud8Tick = 0;
        forever begin
            @(negedge clk);
            Baud8Tick = (t == 15);
            t = (t + 1) % 16;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic pop_check(input string name, input int kind,
                             input logic [7:0] d);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s unexpected strobe actual=%0d required=none",
                     name, kind);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == 0 && e.data !== d)) begin
                bad++;
                $display("FAIL %s actual=%0d/%0h required=%0d/%0h",
                         name, kind, d, e.kind, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (RxD_data_ready && (RxD_frame_err || perr)) begin
            total++;
            bad++;
            $display("FAIL strobe_overlap actual=1 required=0");
        end
        if (RxD_data_ready) begin
            n_ready++;
            rdy_t.push_back(cyc);
            pop_check("ready", 0, RxD_data);
        end
        if (RxD_frame_err) begin
            n_ferr++;
            pop_check("frame_err", 1, 8'h00);
        end
        if (perr) begin
            n_perr++;
            pop_check("parity_err", 2, 8'h00);
        end
    end

    task automatic send_bit(input logic b, input int n);
        RxD = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic par_ok);
        send_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) send_bit(d[i], BIT_CLK);
`ifdef UART_RX_PARITY_EN
        send_bit(par_ok ? ^d : ~^d, BIT_CLK);
`endif
        send_bit(stop, BIT_CLK);
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.data = d;
        exp_q.push_back(e);
        if (kind == 0) want_ready++;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    vec_t vt[3];

    initial begin
        vt[0] = '{d: 8'h55, stop: 1'b1, gap: 2, exp_kind: 0, exp_data: 8'h55};
        vt[1] = '{d: 8'hA3, stop: 1'b1, gap: 0, exp_kind: 0, exp_data: 8'hA3};
        vt[2] = '{d: 8'h0F, stop: 1'b1, gap: 3, exp_kind: 0, exp_data: 8'h0F};

        RxD = 1;
        rst = 1;
        repeat (4) @(negedge clk);
        check("rst_data", RxD_data, 8'h00);
        check("rst_ready", RxD_data_ready, 1'b0);
        check("rst_ferr", RxD_frame_err, 1'b0);
        check("rst_idle", RxD_idle, 1'b1);
        rst = 0;
        repeat (200) @(negedge clk);
        check("idle_quiet", RxD_idle, 1'b1);

        for (int i = 0; i < 3; i++) begin
            expect_ev(vt[i].exp_kind, vt[i].exp_data);
            send_frame(vt[i].d, vt[i].stop, 1'b1);
            send_bit(1'b1, vt[i].gap * BIT_CLK);
        end
        drain("table_drain");
        check("table_data", RxD_data, 8'h0F);
        if (rdy_t.size() >= 3) begin
            check("gap_spacing", rdy_t[1] - rdy_t[0], FRAME_CLK + 2 * BIT_CLK);
            check("b2b_spacing", rdy_t[2] - rdy_t[1], FRAME_CLK);
        end else begin
            check("ready_count", rdy_t.size(), 3);
        end

        for (int off = 0; off < 16; off += 5) begin
            repeat (off + 1) @(negedge clk);
            send_bit(1'b0, 24);
            send_bit(1'b1, 300);
            check("glitch_idle", RxD_idle, 1'b1);
            check("glitch_data", RxD_data, 8'h0F);
        end

        expect_ev(1, 8'h00);
        send_frame(8'h81, 1'b0, 1'b1);
        send_bit(1'b0, FRAME_CLK);
        check("break_idle1", RxD_idle, 1'b0);
        send_bit(1'b0, 2 * FRAME_CLK);
        check("break_idle3", RxD_idle, 1'b0);
        check("break_data", RxD_data, 8'h0F);
        send_bit(1'b1, BIT_CLK);
        check("break_release", RxD_idle, 1'b1);
        drain("break_drain");
        expect_ev(0, 8'h7E);
        send_frame(8'h7E, 1'b1, 1'b1);
        send_bit(1'b1, BIT_CLK);
        drain("after_break");

        send_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) send_bit(1'b1, BIT_CLK);
        send_bit(1'b1, 64);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("mid_rst_data", RxD_data, 8'h00);
        check("mid_rst_idle", RxD_idle, 1'b1);
        send_bit(1'b1, 64 + 4 * BIT_CLK);
        check("post_rst_data", RxD_data, 8'h00);
        expect_ev(0, 8'h12);
        send_frame(8'h12, 1'b1, 1'b1);
        send_bit(1'b1, BIT_CLK);
        drain("after_rst");

`ifdef UART_RX_PARITY_EN
        expect_ev(2, 8'h00);
        send_frame(8'h07, 1'b1, 1'b0);
        send_bit(1'b1, BIT_CLK);
        drain("par_bad");
        check("par_bad_data", RxD_data, 8'h12);
        expect_ev(0, 8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        send_bit(1'b1, BIT_CLK);
        drain("par_good");
        check("par_perr_cnt", n_perr, 1);
`endif

        check("n_ready", n_ready, want_ready);
        check("n_ferr", n_ferr, 1);
        check("final_data", RxD_data, want_ready == 6 ? 8'h07 : 8'h12);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
